// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline register (main + skid) with valid/ready handshake on both sides.
// in_ready comes from registered state only, so out_ready never reaches upstream combinationally.
module pipe_stage_reg #(
  parameter int DATA_W           = 128,
  parameter int OP_W             = 6,
  parameter int WREG_W           = 5,
  parameter int NOP_OP           = 55,
  parameter int ZERO_WREG_ON_NOP = 1
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [WREG_W-1:0] in_wreg,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [WREG_W-1:0] out_wreg,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam logic [OP_W-1:0] LP_NOP = OP_W'(NOP_OP);

  logic              r_main_vld;
  logic [OP_W-1:0]   r_main_op;
  logic [WREG_W-1:0] r_main_wreg;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_vld;
  logic [OP_W-1:0]   r_skid_op;
  logic [WREG_W-1:0] r_skid_wreg;
  logic [DATA_W-1:0] r_skid_data;

  logic              w_accept;
  logic              w_pop;
  logic              w_main_free;
  logic [WREG_W-1:0] w_in_wreg;

  assign in_ready    = !r_skid_vld;
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_pop       = r_main_vld && out_ready;
  assign w_main_free = !r_main_vld || w_pop;

  // Bubbles must not look like writers to downstream hazard logic.
  assign w_in_wreg = ((ZERO_WREG_ON_NOP != 0) && (in_op == LP_NOP)) ? '0 : in_wreg;

  always_ff @(posedge clk) begin
    if (rstd) begin
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_main_op   <= LP_NOP;
      r_main_wreg <= '0;
      r_main_data <= '0;
    end else if (flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_vld) begin
        r_main_vld  <= 1'b1;
        r_main_op   <= r_skid_op;
        r_main_wreg <= r_skid_wreg;
        r_main_data <= r_skid_data;
        r_skid_vld  <= w_accept;
        if (w_accept) begin
          r_skid_op   <= in_op;
          r_skid_wreg <= w_in_wreg;
          r_skid_data <= in_data;
        end
      end else begin
        r_main_vld <= w_accept;
        if (w_accept) begin
          r_main_op   <= in_op;
          r_main_wreg <= w_in_wreg;
          r_main_data <= in_data;
        end
      end
    end else if (w_accept) begin
      r_skid_vld  <= 1'b1;
      r_skid_op   <= in_op;
      r_skid_wreg <= w_in_wreg;
      r_skid_data <= in_data;
    end
  end

  // Payload is deliberately not muxed: it keeps its last value while empty.
  assign out_valid = r_main_vld;
  assign out_op    = r_main_vld ? r_main_op : LP_NOP;
  assign out_wreg  = r_main_vld ? r_main_wreg : '0;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: two instances (8-bit/NOP-zeroing, 200-bit/no-zeroing) share stimulus;
// a queue of expected entries is checked by a negedge monitor, plus directed point checks.
module tb_pipe_stage_reg;

  typedef struct {
    logic [5:0]   op;
    logic [4:0]   wa;
    logic [4:0]   wb;
    logic [199:0] d;
  } ent_t;

  logic         clk = 1'b0;
  logic         rstd = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [5:0]   in_op = '0;
  logic [4:0]   in_wreg = '0;
  logic [199:0] in_data = '0;

  logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [5:0]   a_out_op, b_out_op;
  logic [4:0]   a_out_wreg, b_out_wreg;
  logic [7:0]   a_out_data;
  logic [199:0] b_out_data;
  logic [1:0]   a_occ, b_occ;

  ent_t         q[$];
  logic         acc_now = 1'b0;
  logic         mon_en = 1'b0;
  logic [199:0] last_d = '0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .ZERO_WREG_ON_NOP(1)) u_a (
    .clk(clk), .rstd(rstd), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_op(in_op), .in_wreg(in_wreg),
    .in_data(in_data[7:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_op(a_out_op), .out_wreg(a_out_wreg),
    .out_data(a_out_data), .occupancy(a_occ)
  );

  pipe_stage_reg #(.DATA_W(200), .ZERO_WREG_ON_NOP(0)) u_b (
    .clk(clk), .rstd(rstd), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_op(in_op), .in_wreg(in_wreg),
    .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_op(b_out_op), .out_wreg(b_out_wreg),
    .out_data(b_out_data), .occupancy(b_occ)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drives one cycle of inputs; the entry is queued if the bench model says it gets accepted.
  task automatic cyc(input logic v, input int op, input int wr, input logic [199:0] d,
                     input logic ordy, input logic fl, input logic rs);
    ent_t e;
    @(posedge clk); #2;
    in_valid = v; in_op = op[5:0]; in_wreg = wr[4:0]; in_data = d;
    out_ready = ordy; flush = fl; rstd = rs;
    acc_now = v && (q.size() < 2) && !fl && !rs;
    if (acc_now) begin
      e.op = op[5:0];
      e.wa = (op[5:0] == 6'd55) ? 5'd0 : wr[4:0];
      e.wb = wr[4:0];
      e.d  = d;
      q.push_back(e);
    end
  endtask

  task automatic at_neg;
    @(negedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " out_valid"}, {a_out_valid, b_out_valid}, 2'b00);
    chk({tag, " in_ready"}, {a_in_ready, b_in_ready}, 2'b11);
    chk({tag, " occupancy"}, {a_occ, b_occ}, 4'd0);
    chk({tag, " out_op"}, {a_out_op, b_out_op}, {6'd55, 6'd55});
    chk({tag, " out_wreg"}, {a_out_wreg, b_out_wreg}, 10'd0);
    chk({tag, " out_data"}, {a_out_data, b_out_data}, 208'd0);
  endtask

  // Monitor: compares head against the queue and retires entries on handshake.
  always @(negedge clk) begin
    int held;
    if (mon_en) begin
      held = q.size() - (acc_now ? 1 : 0);
      chk("mon occupancy", {a_occ, b_occ}, {held[1:0], held[1:0]});
      chk("mon out_valid", {a_out_valid, b_out_valid}, {2{held > 0}});
      chk("mon in_ready", {a_in_ready, b_in_ready}, {2{held < 2}});
      if (held > 0) begin
        chk("mon head op", {a_out_op, b_out_op}, {q[0].op, q[0].op});
        chk("mon head wreg", {a_out_wreg, b_out_wreg}, {q[0].wa, q[0].wb});
        chk("mon head data", {a_out_data, b_out_data}, {q[0].d[7:0], q[0].d});
        last_d = q[0].d;
      end else begin
        chk("mon idle op", {a_out_op, b_out_op}, {6'd55, 6'd55});
        chk("mon idle wreg", {a_out_wreg, b_out_wreg}, 10'd0);
        chk("mon idle data", {a_out_data, b_out_data}, {last_d[7:0], last_d});
      end
      if (rstd) begin
        q.delete();
        last_d = '0;
      end else if (flush) begin
        q.delete();
      end else if (held > 0 && out_ready) begin
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [223:0] rnd;
    cyc(0, 0, 0, '0, 0, 0, 1);
    cyc(0, 0, 0, '0, 0, 0, 1);
    mon_en = 1'b1;
    at_neg;
    chk_reset_vals("reset");

    // Passthrough: out_op trails the input by one cycle, never more than one held.
    for (int k = 1; k <= 4; k++) begin
      cyc(1, k, k, 200'(k * 17), 1, 0, 0);
      at_neg;
      if (k > 1) begin
        chk("pass op", a_out_op, 6'(k - 1));
        chk("pass occ", a_occ, 2'd1);
      end
    end
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("pass op last", {a_out_op, b_out_op}, {6'd4, 6'd4});
    chk("pass occ last", a_occ, 2'd1);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("pass drained", a_out_valid, 1'b0);

    // Stall and skid: two held, in_ready low even while out_ready is high.
    cyc(1, 10, 3, 200'hA0A, 0, 0, 0);
    cyc(1, 11, 4, 200'hB0B, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 0, 0);
    at_neg;
    chk("skid occ", {a_occ, b_occ}, {2'd2, 2'd2});
    chk("skid in_ready", {a_in_ready, b_in_ready}, 2'b00);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("skid in_ready ordy", {a_in_ready, b_in_ready}, 2'b00);
    chk("skid first", a_out_op, 6'd10);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("skid second", a_out_op, 6'd11);
    chk("skid occ1", a_occ, 2'd1);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("skid empty", {a_out_valid, b_out_valid}, 2'b00);

    // NOP sanitising differs between the two instances.
    cyc(1, 55, 7, 200'h77, 0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("nop op", {a_out_op, b_out_op}, {6'd55, 6'd55});
    chk("nop wreg", {a_out_wreg, b_out_wreg}, {5'd0, 5'd7});
    chk("nop valid", {a_out_valid, b_out_valid}, 2'b11);
    cyc(0, 0, 0, '0, 1, 0, 0);

    // Flush at occupancy 2 with a live input.
    cyc(1, 20, 1, 200'h20, 0, 0, 0);
    cyc(1, 21, 2, 200'h21, 0, 0, 0);
    cyc(1, 22, 3, 200'h22, 1, 1, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("flush occ", {a_occ, b_occ}, 4'd0);
    chk("flush op", {a_out_op, b_out_op}, {6'd55, 6'd55});
    chk("flush wreg", {a_out_wreg, b_out_wreg}, 10'd0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("flush no deliver", {a_out_valid, b_out_valid}, 2'b00);

    // Flush at occupancy 1: the same-cycle input (in_ready high) must be dropped.
    cyc(1, 30, 1, 200'h30, 0, 0, 0);
    cyc(1, 31, 2, 200'h31, 0, 1, 0);
    cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("flush1 occ", a_occ, 2'd0);

    // Reset wins over flush.
    cyc(1, 40, 5, 200'h40, 0, 0, 0);
    cyc(0, 0, 0, '0, 0, 1, 1);
    cyc(0, 0, 0, '0, 0, 0, 0);
    at_neg;
    chk_reset_vals("rst>flush");

    // Random valid/ready, with rare flush and reset.
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      cyc(($urandom() % 3) != 0, int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
          rnd[199:0], ($urandom() % 3) != 0, ($urandom() % 97) == 0, ($urandom() % 1009) == 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 1, 0, 0);
    at_neg;
    chk("random drained", 256'(q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, the width of the opaque payload bundle (pc, operands, address, immediate, ALU result, memory data concatenated by the parent).
REQ-002 The block SHALL have parameter OP_W, default 6, the opcode width.
REQ-003 The block SHALL have parameter WREG_W, default 5, the write-register index width.
REQ-004 The block SHALL have parameter NOP_OP, default 55, the bubble opcode.
REQ-005 The block SHALL have parameter ZERO_WREG_ON_NOP, default 1, which forces wreg to 0 for NOP entries.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rstd, input, 1 bit, a synchronous active-high reset.
REQ-008 The block SHALL have port flush, input, 1 bit, which kills all held entries.
REQ-009 The block SHALL have port in_valid, input, 1 bit, the upstream entry-valid signal.
REQ-010 The block SHALL have port in_ready, output, 1 bit, which indicates the stage accepts an entry this cycle.
REQ-011 The block SHALL have port in_op, input, OP_W bits, the upstream opcode.
REQ-012 The block SHALL have port in_wreg, input, WREG_W bits, the upstream destination register.
REQ-013 The block SHALL have port in_data, input, DATA_W bits, the upstream payload.
REQ-014 The block SHALL have port out_valid, output, 1 bit, which indicates the head entry is valid.
REQ-015 The block SHALL have port out_ready, input, 1 bit, which indicates downstream accepts the head entry.
REQ-016 The block SHALL have port out_op, output, OP_W bits, the head opcode.
REQ-017 The block SHALL have port out_wreg, output, WREG_W bits, the head destination register.
REQ-018 The block SHALL have port out_data, output, DATA_W bits, the head payload.
REQ-019 The block SHALL have port occupancy, output, 2 bits, the number of held entries (0..2).

Function
REQ-020 The block SHALL hold two entries, main (head) and skid, each consisting of op, wreg, data and a valid bit.
REQ-021 The block SHALL drive in_ready = !skid.valid from registered state only, with no combinational path from out_ready.
REQ-022 An accept SHALL occur when in_valid && in_ready && !flush, and a pop SHALL occur when out_valid && out_ready.
REQ-023 On accept with ZERO_WREG_ON_NOP=1 and in_op==NOP_OP, the block SHALL store wreg as 0, otherwise in_wreg.
REQ-024 out_valid SHALL equal main.valid.
REQ-025 When main is invalid, the block SHALL drive out_op=NOP_OP and out_wreg=0, and out_data SHALL hold its last value.
REQ-026 When main is empty or popped and skid is valid, the block SHALL move skid to main, and SHALL move an accepted input into skid.
REQ-027 When main is empty or popped and skid is invalid, the block SHALL load an accepted input into main, or mark main invalid if no accept occurs.
REQ-028 When main is held (valid and not popped), the block SHALL write an accepted input into skid.
REQ-029 The block SHALL deliver entries in acceptance order and SHALL never drop or duplicate an entry absent flush or reset.
REQ-030 Latency SHALL be 1 cycle: an entry accepted at edge N appears at out_* after edge N when the stage was empty.
REQ-031 An empty stage SHALL sustain a throughput of 1 entry/cycle with out_ready held high.
REQ-032 On flush, the block SHALL clear main.valid and skid.valid at the next edge, discard the same-cycle input, and disregard the same-cycle pop.
REQ-033 The block SHALL give reset priority over flush.
REQ-034 occupancy SHALL equal main.valid + skid.valid.
REQ-035 Occupancy 2 implies in_ready=0, and a simultaneous pop and accept at occupancy 1 SHALL leave occupancy at 1.

Reset
REQ-036 While rstd=1 at an edge, the block SHALL clear both valid bits, set main op to NOP_OP, set main wreg to 0, and set out_data to 0.
REQ-037 After reset, the block SHALL show out_valid=0, in_ready=1, occupancy=0, out_op=NOP_OP and out_wreg=0.
REQ-038 Reset asserted mid-transfer SHALL discard all entries with no partial output.

Verification
REQ-039 The bench SHALL cover a passthrough case: reset, then stream op=1..4 with out_ready=1 -> out_op=1..4 on consecutive cycles one cycle late, occupancy never exceeding 1.
REQ-040 The bench SHALL cover a stall/skid case: out_ready=0, then accept A and B -> occupancy 2, in_ready=0; then out_ready=1 -> A, then B, then out_valid=0.
REQ-041 The bench SHALL cover NOP sanitising: accept op=55 with wreg=7 -> out_op=55, out_wreg=0; with ZERO_WREG_ON_NOP=0 -> out_wreg=7.
REQ-042 The bench SHALL cover a flush: with occupancy 2, assert flush together with in_valid=1 -> next cycle occupancy 0, out_op=55, out_wreg=0, and the input not delivered.
REQ-043 The bench SHALL cover reset over flush: rstd=1 and flush=1 together with occupancy 1 -> reset values of REQ-037.
REQ-044 The bench SHALL cover random valid/ready over 10k cycles with DATA_W=8 and DATA_W=200 -> a scoreboard checks order and no loss or duplication, and in_ready never depends combinationally on out_ready.
